// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART program loader.
// Checksum byte support is enabled by defining UART_PROGRAM_LOADER_CHECKSUM_EN.
package uart_loader_pkg;

  typedef enum logic [2:0] {
    S_SEND_READY,
    S_SIZE,
    S_PROG,
    S_CKSUM,
    S_SEND_REQ,
    S_DONE,
    S_ERROR
  } loader_state_t;

  localparam logic [7:0] READY_BYTE_DEF     = 8'h99;
  localparam logic [7:0] STDIN_REQ_BYTE_DEF = 8'hAA;
  localparam int         SIZE_BYTES         = 4;
  localparam int         WORD_BYTES         = 4;

endpackage

// File: rtl/uart_tx_sequencer.sv
// Turns a held one-byte send request into a single tx_start pulse.
// tx_start doubles as the guard flag, covering the cycle before tx_busy rises.
module uart_tx_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       send_req,
  input  logic [7:0] send_byte,
  input  logic       tx_busy,
  output logic       send_ack,
  output logic       tx_start,
  output logic [7:0] tx_sdata
);

  logic fire;

  assign fire     = send_req & ~tx_busy & ~tx_start & ~reset;
  assign send_ack = fire;

  // tx_sdata only changes on a new start, which requires tx_busy low.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_start <= 1'b0;
      tx_sdata <= 8'h00;
    end else begin
      tx_start <= fire;
      if (fire) tx_sdata <= send_byte;
    end
  end

endmodule

// File: rtl/uart_program_loader.sv
// Boot loader: announces readiness, receives a LE size and program words into imem, then requests stdin.
// Optional trailing XOR checksum byte when UART_PROGRAM_LOADER_CHECKSUM_EN is defined.
module uart_program_loader
  import uart_loader_pkg::*;
#(
  parameter int         IMEM_ADDR_WIDTH = 14,
  parameter logic [7:0] READY_BYTE      = READY_BYTE_DEF,
  parameter logic [7:0] STDIN_REQ_BYTE  = STDIN_REQ_BYTE_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [7:0]                 rx_rdata,
  input  logic                       rx_rdata_ready,
  input  logic                       rx_ferr,
  output logic [7:0]                 tx_sdata,
  output logic                       tx_start,
  input  logic                       tx_busy,
  output logic                       imem_we,
  output logic [IMEM_ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]                imem_wdata,
  output logic                       load_done,
  output logic                       load_error
);

  localparam int          AW        = IMEM_ADDR_WIDTH;
  localparam logic [32:0] MAX_BYTES = 33'(WORD_BYTES) << AW;

  loader_state_t state, state_nxt;
  logic [31:0]   size_q, size_nxt;
  logic [31:0]   word_q, word_nxt;
  logic [1:0]    byte_cnt;
  logic [AW:0]   word_idx, word_idx_inc, num_words;
  logic          rx_ok, rx_bad, last_byte, last_word, size_bad;
  logic          send_req, send_ack;
  logic [7:0]    send_byte;

  assign rx_ok        = rx_rdata_ready & ~rx_ferr;
  assign rx_bad       = rx_rdata_ready & rx_ferr;
  assign size_nxt     = {rx_rdata, size_q[31:8]};
  assign word_nxt     = {rx_rdata, word_q[31:8]};
  assign last_byte    = (byte_cnt == 2'(SIZE_BYTES - 1));
  assign word_idx_inc = word_idx + {{AW{1'b0}}, 1'b1};
  assign last_word    = (word_idx_inc == num_words);
  assign size_bad     = (size_nxt[1:0] != 2'b00) || ({1'b0, size_nxt} > MAX_BYTES);

`ifdef UART_PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0] cksum_q;

  always_ff @(posedge clk) begin
    if (reset)                          cksum_q <= 8'h00;
    else if (state == S_PROG && rx_ok)  cksum_q <= cksum_q ^ rx_rdata;
  end
`endif

  always_comb begin
    state_nxt = state;
    send_req  = 1'b0;
    send_byte = READY_BYTE;
    case (state)
      S_SEND_READY: begin
        send_req = 1'b1;
        if (send_ack) state_nxt = S_SIZE;
      end
      S_SIZE: begin
        if (rx_bad)                       state_nxt = S_ERROR;
        else if (rx_ok && last_byte) begin
          if (size_bad)                   state_nxt = S_ERROR;
          else if (size_nxt == 32'd0)     state_nxt = S_SEND_REQ;
          else                            state_nxt = S_PROG;
        end
      end
      S_PROG: begin
        if (rx_bad)                                  state_nxt = S_ERROR;
`ifdef UART_PROGRAM_LOADER_CHECKSUM_EN
        else if (rx_ok && last_byte && last_word)    state_nxt = S_CKSUM;
`else
        else if (rx_ok && last_byte && last_word)    state_nxt = S_SEND_REQ;
`endif
      end
      S_CKSUM: begin
`ifdef UART_PROGRAM_LOADER_CHECKSUM_EN
        if (rx_bad)     state_nxt = S_ERROR;
        else if (rx_ok) state_nxt = (rx_rdata == cksum_q) ? S_SEND_REQ : S_ERROR;
`else
        state_nxt = S_ERROR;
`endif
      end
      S_SEND_REQ: begin
        send_req  = 1'b1;
        send_byte = STDIN_REQ_BYTE;
        if (send_ack) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_DONE;
      S_ERROR: state_nxt = S_ERROR;
      default: state_nxt = S_ERROR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_SEND_READY;
      size_q     <= 32'd0;
      word_q     <= 32'd0;
      byte_cnt   <= 2'd0;
      word_idx   <= '0;
      num_words  <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'd0;
      load_done  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      state      <= state_nxt;
      imem_we    <= 1'b0;
      load_done  <= (state_nxt == S_DONE);
      load_error <= (state_nxt == S_ERROR);
      if (state == S_SIZE && rx_ok) begin
        size_q   <= size_nxt;
        byte_cnt <= byte_cnt + 2'd1;
        if (last_byte) num_words <= size_nxt[AW+2:2];
      end
      // byte_cnt wraps to 0 after the size field, so word assembly starts aligned.
      if (state == S_PROG && rx_ok) begin
        word_q   <= word_nxt;
        byte_cnt <= byte_cnt + 2'd1;
        if (last_byte) begin
          imem_we    <= 1'b1;
          imem_addr  <= word_idx[AW-1:0];
          imem_wdata <= word_nxt;
          word_idx   <= word_idx_inc;
        end
      end
    end
  end

  uart_tx_sequencer u_tx_seq (
    .clk       (clk),
    .reset     (reset),
    .send_req  (send_req),
    .send_byte (send_byte),
    .tx_busy   (tx_busy),
    .send_ack  (send_ack),
    .tx_start  (tx_start),
    .tx_sdata  (tx_sdata)
  );

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed and randomized loads of uart_program_loader, checked against a byte-stream reference model.
module tb_uart_program_loader;

  localparam int AW  = 4;
  localparam int CAP = 4 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    rx_rdata = 8'h00;
  logic          rx_rdata_ready = 1'b0;
  logic          rx_ferr = 1'b0;
  logic [7:0]    tx_sdata;
  logic          tx_start;
  logic          tx_busy;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          load_done;
  logic          load_error;

  uart_program_loader #(.IMEM_ADDR_WIDTH(AW)) dut (
    .clk            (clk),
    .reset          (reset),
    .rx_rdata       (rx_rdata),
    .rx_rdata_ready (rx_rdata_ready),
    .rx_ferr        (rx_ferr),
    .tx_sdata       (tx_sdata),
    .tx_start       (tx_start),
    .tx_busy        (tx_busy),
    .imem_we        (imem_we),
    .imem_addr      (imem_addr),
    .imem_wdata     (imem_wdata),
    .load_done      (load_done),
    .load_error     (load_error)
  );

  always #5 clk = ~clk;

  // UART TX model: busy for 8 cycles starting the cycle after tx_start.
  int busy_cnt = 0;
  always @(posedge clk) begin
    if (reset)                busy_cnt <= 0;
    else if (tx_start)        busy_cnt <= 8;
    else if (busy_cnt != 0)   busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0);

  logic [7:0]    tx_q[$];
  logic [AW-1:0] wa_q[$];
  logic [31:0]   wd_q[$];

  always @(negedge clk) begin
    if (tx_start) tx_q.push_back(tx_sdata);
    if (imem_we) begin
      wa_q.push_back(imem_addr);
      wd_q.push_back(imem_wdata);
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [7:0]  stim_q[$];
  int          ferr_at;
  logic [31:0] exp_wd[$];
  bit          exp_err;

  // Reference: interpret the byte stream as size field, program words and optional checksum.
  task automatic model();
    longint     size;
    logic [7:0] x;
    exp_wd.delete();
    exp_err = 0;
    if (ferr_at >= 0 && ferr_at < 4) begin exp_err = 1; return; end
    size = longint'({stim_q[3], stim_q[2], stim_q[1], stim_q[0]});
    if (size % 4 != 0 || size > CAP) begin exp_err = 1; return; end
    for (int w = 0; w < size / 4; w++) begin
      if (ferr_at >= 0 && ferr_at < 8 + 4 * w) begin exp_err = 1; return; end
      exp_wd.push_back({stim_q[7+4*w], stim_q[6+4*w], stim_q[5+4*w], stim_q[4+4*w]});
    end
`ifdef UART_PROGRAM_LOADER_CHECKSUM_EN
    if (size > 0) begin
      x = 8'h00;
      for (int i = 4; i < 4 + size; i++) x ^= stim_q[i];
      if (ferr_at == 4 + size || stim_q[4+size] !== x) exp_err = 1;
    end
`endif
  endtask

  task automatic add_cksum();
`ifdef UART_PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0] x = 8'h00;
    for (int i = 4; i < stim_q.size(); i++) x ^= stim_q[i];
    if (stim_q.size() > 4) stim_q.push_back(x);
`endif
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    rx_rdata_ready = 1'b0;
    rx_ferr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tx_q.delete(); wa_q.delete(); wd_q.delete();
    reset = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit ferr);
    @(posedge clk); #1;
    rx_rdata = b; rx_rdata_ready = 1'b1; rx_ferr = ferr;
    @(posedge clk); #1;
    rx_rdata_ready = 1'b0; rx_ferr = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (tx_q.size() == 0 && n < 100) begin @(posedge clk); n++; end
    #1;
    check({tag, "_ready"}, (tx_q.size() > 0) ? 32'(tx_q[0]) : 32'hFFFF_FFFF, 32'h99);
  endtask

  task automatic run_load(input string tag);
    int n;
    do_reset();
    wait_ready(tag);
    for (int i = 0; i < stim_q.size(); i++) send_byte(stim_q[i], i == ferr_at);
    repeat (30) @(posedge clk);
    #1;
    model();
    check({tag, "_nwr"}, wd_q.size(), exp_wd.size());
    n = (wd_q.size() < exp_wd.size()) ? wd_q.size() : exp_wd.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_addr%0d", tag, i), 32'(wa_q[i]), 32'(i % (1 << AW)));
      check($sformatf("%s_data%0d", tag, i), wd_q[i], exp_wd[i]);
    end
    check({tag, "_ntx"}, tx_q.size(), exp_err ? 1 : 2);
    if (!exp_err && tx_q.size() > 1) check({tag, "_req"}, 32'(tx_q[1]), 32'hAA);
    check({tag, "_done"}, load_done, !exp_err);
    check({tag, "_err"}, load_error, exp_err);
  endtask

  task automatic build_random(input int nwords);
    int sz = nwords * 4;
    stim_q = '{8'(sz), 8'(sz >> 8), 8'h00, 8'h00};
    for (int i = 0; i < sz; i++) stim_q.push_back(8'($urandom));
    add_cksum();
  endtask

  initial begin
    // Reset state and the single readiness announcement.
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_start", tx_start, 1'b0);
    check("rst_tx_sdata", tx_sdata, 8'h00);
    check("rst_imem_we", imem_we, 1'b0);
    check("rst_done", load_done, 1'b0);
    check("rst_error", load_error, 1'b0);
    reset = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("boot_ntx", tx_q.size(), 1);
    check("boot_byte", (tx_q.size() > 0) ? 32'(tx_q[0]) : 32'hFFFF_FFFF, 32'h99);

    ferr_at = -1;
    stim_q = '{8'h08, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    add_cksum();
    stim_q.push_back(8'h55);
    run_load("normal");

    stim_q = '{8'h00, 8'h00, 8'h00, 8'h00};
    run_load("size0");

    stim_q = '{8'h06, 8'h00, 8'h00, 8'h00};
    run_load("size6");

    stim_q = '{8'(CAP + 4), 8'((CAP + 4) >> 8), 8'h00, 8'h00};
    run_load("oversize");

    build_random(CAP / 4);
    run_load("fullmem");

    stim_q = '{8'h08, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    ferr_at = 6;
    run_load("ferr_prog");
    ferr_at = 2;
    run_load("ferr_size");
    ferr_at = -1;

    for (int r = 0; r < 4; r++) begin
      build_random(int'($urandom_range(1, 6)));
      ferr_at = (r == 3) ? int'($urandom_range(4, stim_q.size() - 1)) : -1;
      run_load($sformatf("rand%0d", r));
    end
    ferr_at = -1;

    // Abort after 5 program bytes, then a clean reload.
    do_reset();
    wait_ready("abort");
    stim_q = '{8'h08, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    for (int i = 0; i < stim_q.size(); i++) send_byte(stim_q[i], 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_we", imem_we, 1'b0);
    check("abort_nwr", wd_q.size(), 1);
    stim_q = '{8'h04, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    add_cksum();
    run_load("reload");
    check("reload_word", (wd_q.size() > 0) ? wd_q[0] : 32'h0, 32'hDEADBEEF);

`ifdef UART_PROGRAM_LOADER_CHECKSUM_EN
    stim_q = '{8'h04, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
    run_load("cksum_ok");
    check("cksum_ok_const", load_done, 1'b1);
    stim_q = '{8'h04, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    run_load("cksum_bad");
    check("cksum_bad_const", load_error, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
